mem_access_pipe: RTL and testbench

MEM_ACCESS_PIPE -- requirements
Module: mem_access_pipe

---
 rtl/mem_access_pkg.sv | 43 ++++
 rtl/mem_access_pipe_if.sv | 49 ++++
 rtl/ma_stall_counter.sv | 24 ++
 rtl/mem_access_pipe.sv | 118 +++++++++++
 tb/tb_mem_access_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access pipeline stage: control bundles, FSM state
// encoding, write-back source codes and the control-narrowing helper.
package mem_access_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] branch;
    logic       mem_write;
    logic       mem_read;
    logic       uart_to_reg;
  } ma_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] branch;
    logic       uart_to_reg;
  } ma_out_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } ma_state_e;

  // Write-back source selection carried in mem_to_reg.
  localparam logic [1:0] MTR_ALU  = 2'd0;
  localparam logic [1:0] MTR_MEM  = 2'd1;
  localparam logic [1:0] MTR_PC4  = 2'd2;
  localparam logic [1:0] MTR_UART = 2'd3;

  function automatic ma_out_ctrl_t to_out_ctrl(input ma_ctrl_t c);
    ma_out_ctrl_t o;
    o.reg_write   = c.reg_write;
    o.mem_to_reg  = c.mem_to_reg;
    o.branch      = c.branch;
    o.uart_to_reg = c.uart_to_reg;
    return o;
  endfunction

endpackage

// File: rtl/mem_access_pipe_if.sv
// Bundle of upstream, memory and downstream signals of the memory-access stage.
// The stage itself connects through the slave modport; its environment uses master.
interface mem_access_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SIDE_WIDTH = 32
) ();
  // valid/ready: a transfer happens on a rising edge where both are high; once
  // valid is raised the payload stays stable until that transfer occurs.
  logic                          in_valid;
  logic                          in_ready;
  mem_access_pkg::ma_ctrl_t      in_ctrl;
  logic [DATA_WIDTH-1:0]         in_alu_result;
  logic [DATA_WIDTH-1:0]         in_store_data;
  logic [4:0]                    in_rdist;
  logic [SIDE_WIDTH-1:0]         in_side;

  logic                          mem_req;
  logic                          mem_we;
  logic [DATA_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic                          mem_gnt;
  logic                          mem_rvalid;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  logic                          out_valid;
  logic                          out_ready;
  mem_access_pkg::ma_out_ctrl_t  out_ctrl;
  logic [DATA_WIDTH-1:0]         out_read_data;
  logic [DATA_WIDTH-1:0]         out_alu_result;
  logic [DATA_WIDTH-1:0]         out_store_data;
  logic [4:0]                    out_rdist;
  logic [SIDE_WIDTH-1:0]         out_side;

  modport slave (
    input  in_valid, in_ctrl, in_alu_result, in_store_data, in_rdist, in_side,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output out_valid, out_ctrl, out_read_data, out_alu_result, out_store_data,
    output out_rdist, out_side
  );

  modport master (
    output in_valid, in_ctrl, in_alu_result, in_store_data, in_rdist, in_side,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  out_valid, out_ctrl, out_read_data, out_alu_result, out_store_data,
    input  out_rdist, out_side
  );
endinterface

// File: rtl/ma_stall_counter.sv
// Saturating count of memory stall cycles; exists only when MEM_ACCESS_STALL_CNT_EN
// is defined, so the default build carries no counter logic.
`ifdef MEM_ACCESS_STALL_CNT_EN
module ma_stall_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
endmodule
`endif

// File: rtl/mem_access_pipe.sv
// Single-entry memory-access pipeline stage: issues loads/stores to a gnt/rvalid
// memory port and holds results for downstream. MEM_ACCESS_STALL_CNT_EN adds stall_cycles.
module mem_access_pipe
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int INST_MEM_WIDTH = 2,
  parameter int SIDE_WIDTH     = 26 + 3*INST_MEM_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  mem_access_pipe_if.slave bus,
  output ma_state_e        state_o
`ifdef MEM_ACCESS_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  ma_state_e             state_q;
  ma_out_ctrl_t          ctrl_q;
  logic [DATA_WIDTH-1:0] rdata_q, alu_q, store_q;
  logic [4:0]            rdist_q;
  logic [SIDE_WIDTH-1:0] side_q;
  logic                  mem_req_q, mem_we_q, out_valid_q;
  logic                  accept, mem_op;

  // Gated by reset so nothing is offered upstream while the stage is held in reset.
  assign bus.in_ready = reset && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_HOLD) && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign mem_op = bus.in_ctrl.mem_read || bus.in_ctrl.mem_write;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      rdata_q     <= '0;
      alu_q       <= '0;
      store_q     <= '0;
      rdist_q     <= '0;
      side_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ISSUE: if (bus.mem_gnt) begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          // mem_we_q marks a store (including read+write); loads may complete with gnt.
          if (mem_we_q) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end else if (bus.mem_rvalid) begin
            rdata_q     <= bus.mem_rdata;
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: if (bus.mem_rvalid) begin
          rdata_q     <= bus.mem_rdata;
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
        end
        ST_HOLD: if (bus.out_ready) begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
        default: ;
      endcase

      // A new entry overrides the retire above, giving back-to-back flow from HOLD.
      if (accept) begin
        ctrl_q  <= to_out_ctrl(bus.in_ctrl);
        alu_q   <= bus.in_alu_result;
        store_q <= bus.in_store_data;
        rdist_q <= bus.in_rdist;
        side_q  <= bus.in_side;
        rdata_q <= '0;
        if (mem_op) begin
          state_q     <= ST_ISSUE;
          mem_req_q   <= 1'b1;
          mem_we_q    <= bus.in_ctrl.mem_write;
          out_valid_q <= 1'b0;
        end else begin
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = alu_q;
  assign bus.mem_wdata      = store_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_ctrl       = ctrl_q;
  assign bus.out_read_data  = rdata_q;
  assign bus.out_alu_result = alu_q;
  assign bus.out_store_data = store_q;
  assign bus.out_rdist      = rdist_q;
  assign bus.out_side       = side_q;
  assign state_o            = state_q;

`ifdef MEM_ACCESS_STALL_CNT_EN
  ma_stall_counter u_stall_counter (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .en_i    ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
    .count_o (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_access_pipe.sv
// Bench for mem_access_pipe: directed scenarios then randomized traffic against a
// memory-array reference model. Define MEM_ACCESS_STALL_CNT_EN to also check stall_cycles.
module tb_mem_access_pipe;
  import mem_access_pkg::*;

  localparam int DW = 32;
  localparam int SW = 32;
  localparam int EW = 6 + 3*DW + 5 + SW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_pipe_if #(.DATA_WIDTH(DW), .SIDE_WIDTH(SW)) bus ();
  ma_state_e state_o;
`ifdef MEM_ACCESS_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  mem_access_pipe #(.DATA_WIDTH(DW), .INST_MEM_WIDTH(2), .SIDE_WIDTH(SW)) dut (
    .CLK     (clk),
    .reset   (rst_n),
    .bus     (bus),
    .state_o (state_o)
`ifdef MEM_ACCESS_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Memory port and out_ready come either from directed code or the random environment.
  bit          auto_mem = 1'b0, rand_ready = 1'b0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0, m_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        a_gnt = 1'b0, a_rvalid = 1'b0, r_ready = 1'b0;
  logic [31:0] a_rdata = '0;
  assign bus.mem_gnt    = auto_mem ? a_gnt : m_gnt;
  assign bus.mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign bus.mem_rdata  = auto_mem ? a_rdata : m_rdata;
  assign bus.out_ready  = rand_ready ? r_ready : m_ready;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_tests = 0, n_fail = 0;
  bit            occ = 1'b0;
  logic [31:0]   ref_mem[0:63];
  logic [31:0]   resp_mem[0:63];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one entry's output, with stores applied to the model memory in order.
  function automatic logic [EW-1:0] model(input ma_ctrl_t c, input logic [31:0] alu,
                                          input logic [31:0] st, input logic [4:0] rd,
                                          input logic [SW-1:0] side);
    bit          is_store = c.mem_write;
    bit          is_load  = c.mem_read && !c.mem_write;
    logic [31:0] rdv      = is_load ? ref_mem[alu[7:2]] : 32'h0;
    if (is_store) ref_mem[alu[7:2]] = st;
    return {c.reg_write, c.mem_to_reg, c.branch, c.uart_to_reg, rdv, alu, st, rd, side};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] act, held;
    bit            was_held;
    was_held = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        occ      = 1'b0;
        was_held = 1'b0;
        continue;
      end
      act = {bus.out_ctrl, bus.out_read_data, bus.out_alu_result, bus.out_store_data,
             bus.out_rdist, bus.out_side};
      check("in_ready", bus.in_ready, !occ || (bus.out_valid && bus.out_ready));
      if (bus.out_valid) check("valid_req_occ", {bus.mem_req, occ}, 2'b01);
      if (was_held) check("hold_stable", {bus.out_valid, act}, {1'b1, held});
      was_held = bus.out_valid && !bus.out_ready;
      held     = act;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none", act);
        end else begin
          check("out_payload", act, exp_q.pop_front());
        end
        occ = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_ctrl, bus.in_alu_result, bus.in_store_data,
                              bus.in_rdist, bus.in_side));
        occ = 1'b1;
      end
    end
  end

  // ---------------- random memory responder and out_ready ----------------
  initial begin
    bit          pend;
    int          dly;
    logic [31:0] rd;
    pend = 1'b0;
    dly  = 0;
    rd   = '0;
    forever begin
      @(posedge clk);
      #1;
      a_gnt    = 1'b0;
      a_rvalid = 1'b0;
      a_rdata  = $urandom;
      if (rand_ready) r_ready = ($urandom_range(0, 3) != 0);
      if (!auto_mem) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        if (dly == 0) begin
          a_rvalid = 1'b1;
          a_rdata  = rd;
          pend     = 1'b0;
        end else dly--;
      end else if (bus.mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          a_gnt = 1'b1;
          if (bus.mem_we) resp_mem[bus.mem_addr[7:2]] = bus.mem_wdata;
          else begin
            rd  = resp_mem[bus.mem_addr[7:2]];
            dly = $urandom_range(0, 3);
            if (dly == 0) begin
              a_rvalid = 1'b1;
              a_rdata  = rd;
            end else begin
              pend = 1'b1;
              dly--;
            end
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        a_rvalid = 1'b1;  // stray response while nothing is outstanding
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input ma_ctrl_t c, input logic [31:0] alu, input logic [31:0] st,
                      input logic [4:0] rd, input logic [SW-1:0] side);
    int t;
    t = 0;
    bus.in_ctrl       = c;
    bus.in_alu_result = alu;
    bus.in_store_data = st;
    bus.in_rdist      = rd;
    bus.in_side       = side;
    bus.in_valid      = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 64);
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 64 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic ma_ctrl_t mk_ctrl(input bit rw, input bit mr, input bit mw);
    ma_ctrl_t c;
    c           = '0;
    c.reg_write = rw;
    c.mem_read  = mr;
    c.mem_write = mw;
    c.mem_to_reg = mr ? MTR_MEM : MTR_ALU;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ma_ctrl_t c;
    int       op, t;
    logic [31:0] alu;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]  = '0;
      resp_mem[i] = '0;
    end
    bus.in_valid = 1'b0;
    bus.in_ctrl = '0;
    bus.in_alu_result = '0;
    bus.in_store_data = '0;
    bus.in_rdist = '0;
    bus.in_side = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_o, ST_IDLE);
    check("rst_ctl", {bus.out_valid, bus.mem_req, bus.mem_we, bus.in_ready}, 4'b0000);
    check("rst_data", {bus.out_ctrl, bus.out_read_data, bus.out_alu_result,
                       bus.out_store_data, bus.out_rdist, bus.out_side}, '0);
    step();
    rst_n = 1'b1;

    // ALU op: one-cycle latency, read data zero
    m_ready = 1'b1;
    send(mk_ctrl(1, 0, 0), 32'h10, 32'h5555, 5'd5, 32'h1);
    @(negedge clk);
    check("alu_valid", bus.out_valid, 1'b1);
    check("alu_fields", {bus.out_alu_result, bus.out_rdist, bus.out_read_data},
          {32'h10, 5'd5, 32'h0});
    step();

    // load at 0x40: gnt in third request cycle, rvalid in second wait cycle
    ref_mem[16] = 32'hDEADBEEF;
    send(mk_ctrl(1, 1, 0), 32'h40, 32'h0, 5'd3, 32'h2);
    for (int i = 0; i < 3; i++) begin
      m_gnt = (i == 2);
      @(negedge clk);
      check("ld_req", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.in_ready, bus.out_valid},
            {1'b1, 1'b0, 32'h40, 1'b0, 1'b0});
      step();
    end
    m_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_rvalid = (i == 1);
      m_rdata  = (i == 1) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      @(negedge clk);
      check("ld_wait", {bus.mem_req, bus.in_ready, bus.out_valid}, 3'b000);
      step();
    end
    m_rvalid = 1'b0;
    @(negedge clk);
    check("ld_data", {bus.out_valid, bus.out_read_data}, {1'b1, 32'hDEADBEEF});
`ifdef MEM_ACCESS_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 32'd5);
`endif
    step();

    // store of 0x1234 to 0x8 with immediate grant
    send(mk_ctrl(0, 0, 1), 32'h8, 32'h1234, 5'd0, 32'h3);
    m_gnt = 1'b1;
    @(negedge clk);
    check("st_req", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.out_valid},
          {1'b1, 1'b1, 32'h8, 32'h1234, 1'b0});
    step();
    m_gnt = 1'b0;
    @(negedge clk);
    check("st_done", {bus.out_valid, bus.mem_req, bus.mem_we, bus.out_read_data},
          {1'b1, 1'b0, 1'b0, 32'h0});
    step();

    // backpressure in HOLD, then same-cycle retire and accept
    m_ready = 1'b0;
    send(mk_ctrl(1, 0, 0), 32'hAA, 32'h0, 5'd7, 32'h4);
    bus.in_ctrl = mk_ctrl(1, 0, 0);
    bus.in_alu_result = 32'hBB;
    bus.in_rdist = 5'd9;
    bus.in_side = 32'h5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.out_rdist, bus.out_alu_result},
            {1'b1, 1'b0, 5'd7, 32'hAA});
      step();
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_next", {bus.out_valid, bus.out_rdist, bus.out_alu_result},
          {1'b1, 5'd9, 32'hBB});
    step();

    // reset while waiting for load data; late rvalid must be ignored
    send(mk_ctrl(1, 1, 0), 32'h44, 32'h0, 5'd2, 32'h6);
    m_gnt = 1'b1;
    step();
    m_gnt = 1'b0;
    @(negedge clk);
    check("rw_wait", {state_o, bus.out_valid}, {ST_WAIT, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_async", {state_o, bus.out_valid, bus.mem_req}, {ST_IDLE, 1'b0, 1'b0});
    @(negedge clk);
    step();
    rst_n = 1'b1;
`ifdef MEM_ACCESS_STALL_CNT_EN
    check("stall_clr", stall_cycles, 32'd0);
`endif
    m_rvalid = 1'b1;
    m_rdata  = 32'hCAFEF00D;
    step();
    m_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rw_ignore", {state_o, bus.out_valid, bus.out_read_data},
            {ST_IDLE, 1'b0, 32'h0});
    end
    step();

    // randomized traffic
    for (int i = 0; i < 64; i++) resp_mem[i] = ref_mem[i];
    auto_mem   = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) step();
      op = $urandom_range(0, 3);
      c.reg_write   = 1'($urandom);
      c.branch      = 2'($urandom);
      c.uart_to_reg = 1'($urandom);
      c.mem_read    = (op == 1) || (op == 3);
      c.mem_write   = (op == 2) || (op == 3);
      c.mem_to_reg  = (op == 1) ? MTR_MEM : ($urandom_range(0, 1) ? MTR_PC4 : MTR_ALU);
      alu = (op == 0) ? $urandom : (32'($urandom_range(0, 15)) << 2);
      send(c, alu, $urandom, 5'($urandom), $urandom);
    end
    t = 0;
    while ((exp_q.size() != 0) && (t < 200)) begin
      step();
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
